// File: rtl/munoc_burst_arbiter.sv
// munoc_burst_arbiter: round-robin burst arbiter sharing one downstream
// burst channel among NUM_REQ requesters. The grant is held for a whole
// burst, and valid-drop and overrun violations are trapped into a sticky
// error state.
// Optional build macro: MUNOC_BURST_ARB_PRIO_OVERRIDE_EN adds a prio_mask
// input that restricts idle arbitration to the masked requesters whenever
// any of them is requesting.

// Per-requester slice: decodes ownership and steers one requester's beat
// onto the shared channel.
module munoc_burst_arb_lane #(
    parameter int LANE       = 0,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  locked,
    input  logic                  xfer_en,
    input  logic [ID_WIDTH-1:0]   owner_id,
    input  logic                  valid,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  sel_valid,
    output logic                  sel_last,
    output logic [DATA_WIDTH-1:0] sel_data
);
    logic is_owner;

    assign is_owner  = locked && (owner_id == ID_WIDTH'(LANE));
    assign ready     = is_owner && xfer_en;
    assign sel_valid = is_owner && valid;
    assign sel_last  = is_owner && last;
    assign sel_data  = is_owner ? data : '0;
endmodule

module munoc_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          err_clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef MUNOC_BURST_ARB_PRIO_OVERRIDE_EN
    input  logic [NUM_REQ-1:0]            prio_mask,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          down_valid,
    output logic                          down_last,
    output logic [DATA_WIDTH-1:0]         down_data,
    input  logic                          down_ready,
    output logic [ID_WIDTH-1:0]           owner_id,
    output logic                          busy,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [ID_WIDTH-1:0]           err_id
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    localparam logic [1:0] ERR_DROP    = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;

    logic [1:0]          state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [CNT_W-1:0]    beat_cnt;
    logic                locked;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]                 sel_valid;
    logic [NUM_REQ-1:0]                 sel_last;
    logic                               own_valid;
    logic                               own_last;

    logic [NUM_REQ-1:0]  cand;
    logic [NUM_REQ-1:0]  rot;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_idx;

    // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    assign data_v = req_data;
    assign locked = (state == ST_LOCKED);
    assign busy   = locked;
    assign err    = (state == ST_ERROR);

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : gen_lane
            munoc_burst_arb_lane #(
                .LANE       (g),
                .ID_WIDTH   (ID_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .locked    (locked),
                .xfer_en   (enable && down_ready),
                .owner_id  (owner_id),
                .valid     (req_valid[g]),
                .last      (req_last[g]),
                .data      (data_v[g]),
                .ready     (req_ready[g]),
                .sel_valid (sel_valid[g]),
                .sel_last  (sel_last[g]),
                .sel_data  (sel_data[g])
            );
        end
    endgenerate

    // Collapse the one-hot lane selections into the downstream channel.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        down_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_valid = own_valid | sel_valid[i];
            own_last  = own_last  | sel_last[i];
            down_data = down_data | sel_data[i];
        end
    end

    assign down_valid = enable && own_valid;
    assign down_last  = own_last;

    // Candidate set: the priority subset when any priority requester is
    // active, otherwise everyone.
`ifdef MUNOC_BURST_ARB_PRIO_OVERRIDE_EN
    logic [NUM_REQ-1:0] hi_cand;
    assign hi_cand = req_valid & prio_mask;
    assign cand    = (|hi_cand) ? hi_cand : req_valid;
`else
    assign cand = req_valid;
`endif

    // Round-robin pick: rotate so bit 0 is rr_ptr, take the lowest set bit.
    always_comb begin
        rot        = NUM_REQ'({cand, cand} >> rr_ptr);
        pick_found = |cand;
        pick_idx   = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) pick_idx = wrap_add(rr_ptr, k);
        end
    end

    // Arbitration / burst-lock / error FSM; enable=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            owner_id <= '0;
            err_code <= '0;
            err_id   <= '0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!own_valid) begin
                        // Contiguity broken, whether or not downstream is ready.
                        state    <= ST_ERROR;
                        err_code <= ERR_DROP;
                        err_id   <= owner_id;
                    end else if (down_ready) begin
                        if (own_last) begin
                            rr_ptr <= wrap_add(owner_id, 1);
                            state  <= ST_IDLE;
                        end else if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            state    <= ST_ERROR;
                            err_code <= ERR_OVERRUN;
                            err_id   <= owner_id;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (err_clear) begin
                        rr_ptr   <= wrap_add(err_id, 1);
                        err_code <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/munoc_burst_arbiter.md
Name: munoc_burst_arbiter

Overview:
- Round-robin arbiter that shares one downstream burst channel among NUM_REQ requesters.
- Holds the grant for a whole burst, until the beat with last is accepted.
- Polices the burst-contiguity rule: valid must stay high from the first beat to the last beat.
- Sits in front of a shared munoc link or slave port; it is the scheduler for the burst-integrity-checked datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat.
- MAX_BURST, 16, maximum beats per burst before an overrun error (>=1).
- ID_WIDTH, 2, width of the owner/error ID; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  clock enable; 0 freezes all state.
- err_clear  in  1  clears the sticky error state.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester last-beat flag.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester ready.
- down_valid  out  1  downstream valid.
- down_last  out  1  downstream last.
- down_data  out  DATA_WIDTH  downstream payload.
- down_ready  in  1  downstream ready.
- owner_id  out  ID_WIDTH  current grant owner.
- busy  out  1  a burst is locked.
- err  out  1  sticky protocol error.
- err_code  out  2  01 = valid dropped mid-burst, 10 = burst overrun.
- err_id  out  ID_WIDTH  requester that caused the error.

Behaviour:
- Reset: one clock, synchronous, active-high. With rst=1 on a rising edge: state=IDLE, rr_ptr=0, beat_cnt=0, owner_id=0, err=0, err_code=0, err_id=0. Combinational outputs are then req_ready=0, down_valid=0, down_last=0, down_data=0 and busy=0. rst has priority over enable and err_clear.
- enable=0: no register updates. down_valid=0 and req_ready=0 combinationally, so no handshakes occur. State resumes unchanged when enable returns to 1.
- States: IDLE, LOCKED, ERROR.
- IDLE, transitions:
  - Any req_valid=1 → pick the first asserted index searching from rr_ptr upward with wrap.
  - Register it as owner_id, set beat_cnt=0, go to LOCKED.
  - Arbitration costs exactly one cycle; no data passes in IDLE.
- IDLE, outputs: down_valid=0, req_ready=0.
- LOCKED, datapath:
  - down_valid=req_valid[owner], down_last=req_last[owner], down_data=req_data[owner], all combinational.
  - req_ready[owner]=down_ready; all other req_ready bits are 0.
  - busy=1.
- LOCKED, on an accepted beat (down_valid & down_ready):
  - With last=1 → rr_ptr=owner+1 (wrapping at NUM_REQ), go to IDLE. The next grant is therefore at least one cycle later.
  - Else, if beat_cnt+1 == MAX_BURST → go to ERROR with err_code=10.
  - Else → beat_cnt increments.
- LOCKED, valid drop: req_valid[owner]=0 at any cycle → go to ERROR with err_code=01 and err_id=owner. This applies even while down_ready=0.
- ERROR:
  - err=1; down_valid=0, req_ready=0, busy=0.
  - The state is sticky until err_clear=1, which returns to IDLE with err=0 and rr_ptr=err_id+1.
  - err_clear has no effect outside ERROR.
- Single-beat burst (last on the first beat) is legal: two cycles minimum per burst (one arbitration cycle plus one beat).
- A requester asserting req_last without valid is ignored.
- beat_cnt width is clog2(MAX_BURST+1); MAX_BURST=1 permits only single-beat bursts.

Optional Feature:
- Macro: MUNOC_BURST_ARB_PRIO_OVERRIDE_EN.
- Defined:
  - Adds input prio_mask[NUM_REQ].
  - In IDLE, if any req_valid & prio_mask is set, arbitrate round-robin among those bits only; otherwise among all requesters.
  - Once LOCKED, behaviour is unchanged.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
- Reset, then req_valid=4'b0110 and each requester sends a 3-beat burst with down_ready=1 → owner_id sequence is 1 then 2; each burst is 4 cycles (arbitration + 3 beats); rr_ptr=3 afterwards.
- All four requesters valid continuously, with 1-beat bursts → grants 0,1,2,3,0, one every 2 cycles; req_ready is never set for a non-owner.
- Owner 2 drops req_valid after beat 1 of 4 → err=1, err_code=01, err_id=2; down_valid=0 thereafter; after err_clear pulse the next grant searches from 3.
- MAX_BURST=4, owner sends 5 beats without last → err_code=10 on acceptance of beat 4, err_id=owner.
- down_ready=0 for 5 cycles mid-burst while owner holds valid → no error, down_data stable, beat_cnt unchanged; rst=1 asserted mid-burst → IDLE next edge with all outputs at reset values.
- enable=0 for 3 cycles mid-burst → no beats accepted, state and beat_cnt held, burst completes correctly after re-enable.
